rv32i_instr_encoder: RTL

Pipelined RV32I instruction encoder, the inverse of the core's immediate-extraction path. It accepts an opcode, register fields, function fields and a 32-bit immediate, checks that the immediate fits the format implied by the opcode, and scatters the immediate bits into a 32-bit instruction word. It sits in the debug/boot-injection path, where it builds instructions for the fetch stage and for the self-test sequencer. It uses valid/ready handshakes on both sides, has a two-stage pipeline and keeps a saturating error counter.

---
 rtl/rv32i_pkg.sv | 52 +++++
 rtl/rv32i_instr_encoder_if.sv | 31 +++
 rtl/rv32i_imm_pack.sv | 52 +++++
 rtl/rv32i_instr_encoder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the encoder, decoder and immediate extractor:
// opcodes, the instruction-format enum, and the stage-1 request record.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_bits;
    logic        legal;
  } enc_req_t;

  function automatic fmt_e opcode_to_fmt(input logic [6:0] opc);
    case (opc)
      OPC_OP:                                             return FMT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM,
      OPC_MISC_MEM:                                       return FMT_I;
      OPC_STORE:                                          return FMT_S;
      OPC_BRANCH:                                         return FMT_B;
      OPC_LUI, OPC_AUIPC:                                 return FMT_U;
      OPC_JAL:                                            return FMT_J;
      default:                                            return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// Request/response bundle of the instruction encoder; master drives requests
// and accepts words, slave is the encoder.
interface rv32i_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;
  logic        err_clr;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready, err_clr,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready, err_clr,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/rv32i_imm_pack.sv
// Scatters a decoder-form immediate into its instruction bit positions and
// reports whether the value is representable in the given format.
module rv32i_imm_pack
  import rv32i_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic [31:0] i_imm,
  output logic [31:0] o_imm_bits,
  output logic        o_legal
);

  logic w_hi11_ok;
  logic w_hi12_ok;
  logic w_hi20_ok;

  // Sign-extension check: every bit above the field must match the sign bit.
  assign w_hi11_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_hi12_ok = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_hi20_ok = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    o_imm_bits = '0;
    o_legal    = 1'b0;
    case (i_fmt)
      FMT_R: o_legal = 1'b1;
      FMT_I: begin
        o_imm_bits = {i_imm[11:0], 20'b0};
        o_legal    = w_hi11_ok;
      end
      FMT_S: begin
        o_imm_bits = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
        o_legal    = w_hi11_ok;
      end
      FMT_B: begin
        o_imm_bits = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
        o_legal    = w_hi12_ok & ~i_imm[0];
      end
      FMT_U: begin
        o_imm_bits = {i_imm[31:12], 12'b0};
        o_legal    = ~(|i_imm[11:0]);
      end
      FMT_J: begin
        o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
        o_legal    = w_hi20_ok & ~i_imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Two-stage RV32I instruction encoder with valid/ready on both sides and a
// saturating count of error words delivered to the consumer.
module rv32i_instr_encoder
  import rv32i_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  rv32i_instr_encoder_if.slave  bus
);

  fmt_e        w_fmt;
  logic [31:0] w_imm_bits;
  logic        w_legal;
  enc_req_t    w_req;

  logic        r_s1_valid;
  enc_req_t    r_s1;
  logic        r_s2_valid;
  logic [31:0] r_s2_instr;
  logic        r_s2_err;
  logic [7:0]  r_err_count;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_accept;
  logic        w_out_fire;
  logic [31:0] w_word;
  logic        w_err;

  assign w_fmt = opcode_to_fmt(bus.in_opcode);

  rv32i_imm_pack u_imm_pack (
    .i_fmt      (w_fmt),
    .i_imm      (bus.in_imm),
    .o_imm_bits (w_imm_bits),
    .o_legal    (w_legal)
  );

  assign w_req = '{fmt:      w_fmt,
                   opcode:   bus.in_opcode,
                   rd:       bus.in_rd,
                   rs1:      bus.in_rs1,
                   rs2:      bus.in_rs2,
                   funct3:   bus.in_funct3,
                   funct7:   bus.in_funct7,
                   imm_bits: w_imm_bits,
                   legal:    w_legal};

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign bus.in_ready = !rst && w_s1_adv;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_out_fire   = r_s2_valid && bus.out_ready;

  always_comb begin
    w_word      = r_s1.imm_bits;
    w_word[6:0] = r_s1.opcode;
    w_err       = !r_s1.legal;
    case (r_s1.fmt)
      FMT_R: begin
        w_word[11:7]  = r_s1.rd;
        w_word[14:12] = r_s1.funct3;
        w_word[19:15] = r_s1.rs1;
        w_word[24:20] = r_s1.rs2;
        w_word[31:25] = r_s1.funct7;
      end
      FMT_I: begin
        w_word[11:7]  = r_s1.rd;
        w_word[14:12] = r_s1.funct3;
        w_word[19:15] = r_s1.rs1;
      end
      FMT_S, FMT_B: begin
        w_word[14:12] = r_s1.funct3;
        w_word[19:15] = r_s1.rs1;
        w_word[24:20] = r_s1.rs2;
      end
      FMT_U, FMT_J: w_word[11:7] = r_s1.rd;
      default: ;
    endcase
    if (w_err) begin
      w_word = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1 <= w_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_word;
        r_s2_err   <= w_err;
      end
    end
  end

  // A clear in the same cycle as an error handshake wins; that error is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (bus.err_clr) begin
      r_err_count <= '0;
    end else if (w_out_fire && r_s2_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_instr = r_s2_instr;
  assign bus.out_err   = r_s2_err;
  assign bus.err_count = r_err_count;

endmodule
